// File: rtl/mux_dreg_bank_pkg.sv
// Shared encodings and helpers for the mux_dreg_bank storage bank.
package mux_dreg_bank_pkg;

  localparam logic [1:0] MODE_HOLD  = 2'b00;
  localparam logic [1:0] MODE_LOAD  = 2'b01;
  localparam logic [1:0] MODE_SHIFT = 2'b10;
  localparam logic [1:0] MODE_ROT   = 2'b11;

  // Per-cell next-value source select.
  localparam logic [1:0] SEL_HOLD  = 2'd0;
  localparam logic [1:0] SEL_LOAD  = 2'd1;
  localparam logic [1:0] SEL_CHAIN = 2'd2;

  function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/mux_dreg_cell.sv
// One WIDTH-bit storage word with a hold / load / chain next-value mux.
module mux_dreg_cell
  import mux_dreg_bank_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] chain_data,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] word_d, word_q;

  always_comb begin
    word_d = word_q;
    case (sel)
      SEL_LOAD:  word_d = load_data;
      SEL_CHAIN: word_d = chain_data;
      default:   word_d = word_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= RESET_VAL;
    end else begin
      word_q <= word_d;
    end
  end

  assign q = word_q;

endmodule

// File: rtl/mux_dreg_bank.sv
// Bank of CHANNELS clocked words with hold, masked load, shift and rotate modes.
// Define MUX_DREG_BANK_UPD_CNT_EN to add the saturating upd_cnt output.
module mux_dreg_bank
  import mux_dreg_bank_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      CHANNELS  = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int unsigned      CNT_W     = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [CHANNELS-1:0]       ch_mask,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [WIDTH-1:0]          ser_in,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [WIDTH-1:0]          ser_out,
  output logic                      upd
`ifdef MUX_DREG_BANK_UPD_CNT_EN
  ,
  output logic [CNT_W-1:0]          upd_cnt
`endif
);

  logic accepted;
  logic upd_q;

  always_comb begin
    accepted = 1'b0;
    if (en) begin
      case (mode)
        MODE_LOAD:  accepted = |ch_mask;
        MODE_SHIFT: accepted = 1'b1;
        MODE_ROT:   accepted = 1'b1;
        default:    accepted = 1'b0;
      endcase
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_cell
    logic [1:0]       sel;
    logic [WIDTH-1:0] chain;

    // Channel 0 takes ser_in or wraps the top word; others take their lower neighbour.
    if (i == 0) begin : g_head
      assign chain = (mode == MODE_ROT) ? q[ch_lsb(CHANNELS - 1, WIDTH) +: WIDTH] : ser_in;
    end else begin : g_body
      assign chain = q[ch_lsb(i - 1, WIDTH) +: WIDTH];
    end

    always_comb begin
      sel = SEL_HOLD;
      if (en) begin
        case (mode)
          MODE_LOAD:  sel = ch_mask[i] ? SEL_LOAD : SEL_HOLD;
          MODE_SHIFT: sel = SEL_CHAIN;
          MODE_ROT:   sel = SEL_CHAIN;
          default:    sel = SEL_HOLD;
        endcase
      end
    end

    mux_dreg_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_cell (
      .clk        (clk),
      .rst_n      (rst_n),
      .sel        (sel),
      .load_data  (d[ch_lsb(i, WIDTH) +: WIDTH]),
      .chain_data (chain),
      .q          (q[ch_lsb(i, WIDTH) +: WIDTH])
    );
  end

  assign ser_out = q[ch_lsb(CHANNELS - 1, WIDTH) +: WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_q <= 1'b0;
    end else begin
      upd_q <= accepted;
    end
  end

  assign upd = upd_q;

`ifdef MUX_DREG_BANK_UPD_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (accepted && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign upd_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_mux_dreg_bank.sv
// Randomized self-checking bench for mux_dreg_bank against an array-based reference model.
module tb_mux_dreg_bank;

  localparam int unsigned W = 8;
  localparam int unsigned C = 4;
  localparam int unsigned CW = 2;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [1:0]     mode;
  logic [C-1:0]   ch_mask;
  logic [C*W-1:0] d;
  logic [W-1:0]   ser_in;
  logic [C*W-1:0] q;
  logic [W-1:0]   ser_out;
  logic           upd;
`ifdef MUX_DREG_BANK_UPD_CNT_EN
  logic [CW-1:0]  upd_cnt;
  int             exp_cnt;
`endif

  logic [W-1:0] m [C];
  logic         m_upd;
  int           checks = 0;
  int           failures = 0;

  always #5 clk = ~clk;

  mux_dreg_bank #(
    .WIDTH     (W),
    .CHANNELS  (C),
    .RESET_VAL ('0),
    .CNT_W     (CW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .mode    (mode),
    .ch_mask (ch_mask),
    .d       (d),
    .ser_in  (ser_in),
    .q       (q),
    .ser_out (ser_out),
    .upd     (upd)
`ifdef MUX_DREG_BANK_UPD_CNT_EN
    ,
    .upd_cnt (upd_cnt)
`endif
  );

  function automatic logic [C*W-1:0] model_q();
    logic [C*W-1:0] r;
    for (int i = 0; i < int'(C); i++) r[i*W +: W] = m[i];
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(C); i++) m[i] = '0;
    m_upd = 1'b0;
`ifdef MUX_DREG_BANK_UPD_CNT_EN
    exp_cnt = 0;
`endif
  endtask

  // Drive one operation, let one edge pass, then advance the model.
  task automatic apply(input logic e, input logic [1:0] md, input logic [C-1:0] mk,
                       input logic [C*W-1:0] dd, input logic [W-1:0] si);
    logic [W-1:0] nxt [C];
    logic         acc;
    en = e; mode = md; ch_mask = mk; d = dd; ser_in = si;
    nxt = m;
    acc = 1'b0;
    if (e && md == 2'b01 && mk != '0) begin
      acc = 1'b1;
      for (int i = 0; i < int'(C); i++) if (mk[i]) nxt[i] = dd[i*W +: W];
    end else if (e && md[1]) begin
      acc = 1'b1;
      nxt[0] = md[0] ? m[C-1] : si;
      for (int i = 1; i < int'(C); i++) nxt[i] = m[i-1];
    end
    @(posedge clk);
    #1;
    m = nxt;
    m_upd = acc;
`ifdef MUX_DREG_BANK_UPD_CNT_EN
    if (acc && exp_cnt < (1 << CW) - 1) exp_cnt++;
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; mode = 2'b00; ch_mask = '0; d = '0; ser_in = '0;
    model_reset();
    #12;
    checks++;
    if (q !== 32'h0 || upd !== 1'b0 || ser_out !== 8'h0) begin
      failures++;
      $display("FAIL reset q=%h upd=%b ser_out=%h required q=0 upd=0 ser_out=0", q, upd, ser_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    apply(1'b1, 2'b01, 4'b0101, 32'hDDCCBBAA, 8'h00);
    checks++;
    if (q !== 32'h00CC00AA || upd !== 1'b1) begin
      failures++;
      $display("FAIL load_masked q=%h upd=%b required q=00cc00aa upd=1", q, upd);
    end
    apply(1'b1, 2'b01, 4'b0000, 32'h12345678, 8'h00);
    checks++;
    if (q !== 32'h00CC00AA || upd !== 1'b0) begin
      failures++;
      $display("FAIL load_nomask q=%h upd=%b required q=00cc00aa upd=0", q, upd);
    end
  endtask

  task automatic test_shift();
    logic [W-1:0] vals [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 2'b10, $urandom, $urandom, vals[i]);
      checks++;
      if (q !== model_q() || upd !== 1'b1) begin
        failures++;
        $display("FAIL shift_step%0d q=%h upd=%b required q=%h upd=1", i, q, upd, model_q());
      end
    end
    checks++;
    if (q !== 32'h11223344 || ser_out !== 8'h11) begin
      failures++;
      $display("FAIL shift_x4 q=%h ser_out=%h required q=11223344 ser_out=11", q, ser_out);
    end
    apply(1'b1, 2'b10, 4'h0, 32'h0, vals[4]);
    checks++;
    if (q !== 32'h22334455) begin
      failures++;
      $display("FAIL shift_5th q=%h required 22334455", q);
    end
  endtask

  task automatic test_rotate();
    apply(1'b1, 2'b01, 4'hF, 32'h11223344, 8'h00);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 2'b11, $urandom, $urandom, $urandom);
      if (i == 0) begin
        checks++;
        if (q !== 32'h22334411) begin
          failures++;
          $display("FAIL rotate_1 q=%h required 22334411", q);
        end
      end
      checks++;
      if (upd !== 1'b1 || q !== model_q()) begin
        failures++;
        $display("FAIL rotate_step%0d q=%h upd=%b required q=%h upd=1", i, q, upd, model_q());
      end
    end
    checks++;
    if (q !== 32'h11223344) begin
      failures++;
      $display("FAIL rotate_x4 q=%h required 11223344", q);
    end
  endtask

  task automatic test_enable();
    apply(1'b0, 2'b01, 4'hF, 32'hFFFFFFFF, 8'hFF);
    checks++;
    if (q !== 32'h11223344 || upd !== 1'b0) begin
      failures++;
      $display("FAIL enable_off q=%h upd=%b required q=11223344 upd=0", q, upd);
    end
    apply(1'b1, 2'b00, 4'hF, 32'hFFFFFFFF, 8'hFF);
    checks++;
    if (q !== 32'h11223344 || upd !== 1'b0) begin
      failures++;
      $display("FAIL hold q=%h upd=%b required q=11223344 upd=0", q, upd);
    end
  endtask

  task automatic test_reset_midrun();
    apply(1'b1, 2'b01, 4'hF, 32'h44332211, 8'h00);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (q !== 32'h0 || upd !== 1'b0 || ser_out !== 8'h0) begin
      failures++;
      $display("FAIL reset_midrun q=%h upd=%b ser_out=%h required all 0", q, upd, ser_out);
    end
    en = 1'b1; mode = 2'b10; ser_in = 8'hAA;
    @(posedge clk);
    #1;
    checks++;
    if (q !== 32'h0 || upd !== 1'b0) begin
      failures++;
      $display("FAIL reset_held q=%h upd=%b required q=0 upd=0", q, upd);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      apply(($urandom_range(0, 7) != 0), 2'($urandom), 4'($urandom), $urandom, 8'($urandom));
      checks++;
      if (q !== model_q() || upd !== m_upd || ser_out !== m[C-1]) begin
        failures++;
        $display("FAIL random%0d q=%h upd=%b ser_out=%h required q=%h upd=%b ser_out=%h",
                 n, q, upd, ser_out, model_q(), m_upd, m[C-1]);
      end
`ifdef MUX_DREG_BANK_UPD_CNT_EN
      checks++;
      if (int'(upd_cnt) != exp_cnt) begin
        failures++;
        $display("FAIL random_cnt%0d upd_cnt=%0d required %0d", n, upd_cnt, exp_cnt);
      end
`endif
    end
  endtask

`ifdef MUX_DREG_BANK_UPD_CNT_EN
  task automatic test_counter();
    test_reset();
    for (int i = 0; i < 5; i++) apply(1'b1, 2'b10, 4'h0, 32'h0, 8'($urandom));
    apply(1'b1, 2'b00, 4'h0, 32'h0, 8'h0);
    apply(1'b0, 2'b11, 4'h0, 32'h0, 8'h0);
    checks++;
    if (upd_cnt !== 2'd3) begin
      failures++;
      $display("FAIL cnt_saturate upd_cnt=%0d required 3", upd_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (upd_cnt !== 2'd0) begin
      failures++;
      $display("FAIL cnt_reset upd_cnt=%0d required 0", upd_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_reset();
    test_shift();
    test_rotate();
    test_enable();
    test_reset_midrun();
    test_random();
`ifdef MUX_DREG_BANK_UPD_CNT_EN
    test_counter();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
